// File: rtl/hamming_codec_arbiter_if.sv
// Request/response bundle between the two requesters, the response consumer
// and the shared Hamming(8,4) codec arbiter.
interface hamming_codec_arbiter_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 3;
    localparam int unsigned ERR_W  = 2;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_mode;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_mode;
    logic [DATA_W-1:0] req1_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic              rsp_mode;
    logic [DATA_W-1:0] rsp_data;
    logic [SYN_W-1:0]  rsp_syndrome;
    logic [ERR_W-1:0]  rsp_err;

    // Requester/consumer side of the bundle.
    modport master (
        output req0_valid, req0_mode, req0_data,
        output req1_valid, req1_mode, req1_data,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_syndrome, rsp_err,
        output rsp_ready
    );

    // Arbiter side of the bundle.
    modport slave (
        input  req0_valid, req0_mode, req0_data,
        input  req1_valid, req1_mode, req1_data,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_syndrome, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/hamming_codec_arbiter.sv
// Two-requester arbiter in front of a shared combinational Hamming(8,4)
// encoder/decoder pair, with a registered tagged response channel and
// saturating corrected/uncorrectable decode counters.
module hamming_codec_arbiter #(
    parameter int unsigned CNT_W      = 8,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_codec_arbiter_if.slave bus,
    output logic [7:0]             cdc_operand,
    output logic                   cdc_mode,
    input  logic [7:0]             enc_code_in,
    input  logic [7:0]             dec_data_in,
    input  logic [2:0]             dec_syndrome_in,
    input  logic [1:0]             dec_err_in,
    input  logic                   cnt_clear,
    output logic [CNT_W-1:0]       cnt_corrected,
    output logic [CNT_W-1:0]       cnt_uncorr,
    output logic                   busy
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 3;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic                id_q;
    logic                cdc_mode_q;
    logic [DATA_W-1:0]   cdc_operand_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic                rsp_mode_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [SYN_W-1:0]    rsp_syndrome_q;
    logic [ERR_W-1:0]    rsp_err_q;
    logic [CNT_W-1:0]    cnt_corr_q;
    logic [CNT_W-1:0]    cnt_unc_q;

    logic                idle_c;
    logic                grant_c;
    logic                accept_c;
    logic                sel_mode_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic                inc_corr_c;
    logic                inc_unc_c;

    assign idle_c = (state_q == IDLE);

    // Pick the requester to serve: sole requester wins, ties by priority mode.
    always_comb begin
        grant_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign bus.req0_ready = idle_c & bus.req0_valid & ~grant_c;
    assign bus.req1_ready = idle_c & bus.req1_valid &  grant_c;
    assign accept_c       = bus.req0_ready | bus.req1_ready;
    assign sel_mode_c     = grant_c ? bus.req1_mode : bus.req0_mode;
    assign sel_data_c     = grant_c ? bus.req1_data : bus.req0_data;

    // Decode outcomes counted on the EXEC capture cycle only.
    assign inc_corr_c = (state_q == EXEC) && cdc_mode_q && (dec_err_in == 2'b01);
    assign inc_unc_c  = (state_q == EXEC) && cdc_mode_q && dec_err_in[1];

    // Operation sequencer: accept, drive codec, capture result, hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            id_q           <= 1'b0;
            cdc_mode_q     <= 1'b0;
            cdc_operand_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_mode_q     <= 1'b0;
            rsp_data_q     <= '0;
            rsp_syndrome_q <= '0;
            rsp_err_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        state_q       <= EXEC;
                        last_grant_q  <= grant_c;
                        id_q          <= grant_c;
                        cdc_mode_q    <= sel_mode_c;
                        cdc_operand_q <= sel_mode_c ? sel_data_c
                                                    : {4'b0000, sel_data_c[3:0]};
                    end
                end
                EXEC: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_mode_q  <= cdc_mode_q;
                    if (cdc_mode_q) begin
                        rsp_data_q     <= dec_data_in;
                        rsp_syndrome_q <= dec_syndrome_in;
                        rsp_err_q      <= dec_err_in;
                    end else begin
                        rsp_data_q     <= enc_code_in;
                        rsp_syndrome_q <= '0;
                        rsp_err_q      <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Saturating error statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            if (inc_corr_c && !(&cnt_corr_q)) begin
                cnt_corr_q <= cnt_corr_q + CNT_W'(1);
            end
            if (inc_unc_c && !(&cnt_unc_q)) begin
                cnt_unc_q <= cnt_unc_q + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_mode     = rsp_mode_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_syndrome = rsp_syndrome_q;
    assign bus.rsp_err      = rsp_err_q;
    assign cdc_operand      = cdc_operand_q;
    assign cdc_mode         = cdc_mode_q;
    assign cnt_corrected    = cnt_corr_q;
    assign cnt_uncorr       = cnt_unc_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Bench for hamming_codec_arbiter: round-robin/2-bit-counter instance with a
// scoreboard, plus a fixed-priority instance for the priority scenario.
module tb_hamming_codec_arbiter;
    localparam int unsigned CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    hamming_codec_arbiter_if ifr ();
    hamming_codec_arbiter_if ifp ();

    // Reference Hamming(8,4) SECDED: positions 1..7 in bits 7:1, overall parity in bit 0.
    function automatic logic [7:0] ham_enc(input logic [3:0] d);
        logic [7:1] c;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return {c, ^c};
    endfunction

    // Returns {data[7:0], syndrome[2:0], err[1:0]}.
    function automatic logic [12:0] ham_dec(input logic [7:0] w);
        logic [2:0] s;
        logic [7:0] f;
        logic [1:0] e;
        s[0] = w[1] ^ w[3] ^ w[5] ^ w[7];
        s[1] = w[2] ^ w[3] ^ w[6] ^ w[7];
        s[2] = w[4] ^ w[5] ^ w[6] ^ w[7];
        f = w;
        if (^w) begin
            e = 2'b01;
            f[s] = ~f[s];
        end else if (s != 3'd0) begin
            e = 2'b10;
        end else begin
            e = 2'b00;
        end
        return {4'b0000, f[7], f[6], f[5], f[3], s, e};
    endfunction

    // Expected response word {id, mode, data, syndrome, err}.
    function automatic logic [14:0] mk_exp(input logic id, input logic mode, input logic [7:0] d);
        logic [12:0] r;
        if (mode) r = ham_dec(d);
        else      r = {ham_enc(d[3:0]), 5'b00000};
        return {id, mode, r};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DUT side signals
    logic [7:0]       cdc_op_r, cdc_op_p;
    logic             cdc_md_r, cdc_md_p;
    logic [7:0]       enc_r, enc_p;
    logic [12:0]      dec_r, dec_p;
    logic             clr_r;
    logic [CNT_W-1:0] corr_r, unc_r, corr_p, unc_p;
    logic             busy_r, busy_p;

    // Behavioural codecs fed from each DUT's operand register.
    always_comb begin
        enc_r = ham_enc(cdc_op_r[3:0]);
        dec_r = ham_dec(cdc_op_r);
        enc_p = ham_enc(cdc_op_p[3:0]);
        dec_p = ham_dec(cdc_op_p);
    end

    hamming_codec_arbiter #(.CNT_W(CNT_W), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .bus(ifr),
        .cdc_operand(cdc_op_r), .cdc_mode(cdc_md_r),
        .enc_code_in(enc_r), .dec_data_in(dec_r[12:5]),
        .dec_syndrome_in(dec_r[4:2]), .dec_err_in(dec_r[1:0]),
        .cnt_clear(clr_r), .cnt_corrected(corr_r), .cnt_uncorr(unc_r), .busy(busy_r)
    );

    hamming_codec_arbiter #(.CNT_W(CNT_W), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .bus(ifp),
        .cdc_operand(cdc_op_p), .cdc_mode(cdc_md_p),
        .enc_code_in(enc_p), .dec_data_in(dec_p[12:5]),
        .dec_syndrome_in(dec_p[4:2]), .dec_err_in(dec_p[1:0]),
        .cnt_clear(1'b0), .cnt_corrected(corr_p), .cnt_uncorr(unc_p), .busy(busy_p)
    );

    // Scoreboard / monitor for the round-robin instance
    logic [14:0] exp_q[$];
    bit          grant_log[$];
    int          grant_cyc[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        prev_rv = 1'b0;
    int          fp_r1_bad = 0;
    bit          fp_grants[$];

    always @(negedge clk) begin
        logic [14:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            prev_rv = 1'b0;
        end else begin
            if (ifr.req0_valid && ifr.req0_ready) begin
                exp_q.push_back(mk_exp(1'b0, ifr.req0_mode, ifr.req0_data));
                grant_log.push_back(1'b0);
                grant_cyc.push_back(cyc);
                acc_cyc = cyc;
            end
            if (ifr.req1_valid && ifr.req1_ready) begin
                exp_q.push_back(mk_exp(1'b1, ifr.req1_mode, ifr.req1_data));
                grant_log.push_back(1'b1);
                grant_cyc.push_back(cyc);
                acc_cyc = cyc;
            end
            if (ifr.rsp_valid && !prev_rv)
                check_eq("latency", 32'(cyc - acc_cyc), 32'd2);
            if (ifr.rsp_valid && ifr.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_id",   32'(ifr.rsp_id),       32'(e[14]));
                    check_eq("rsp_mode", 32'(ifr.rsp_mode),     32'(e[13]));
                    check_eq("rsp_data", 32'(ifr.rsp_data),     32'(e[12:5]));
                    check_eq("rsp_syn",  32'(ifr.rsp_syndrome), 32'(e[4:2]));
                    check_eq("rsp_err",  32'(ifr.rsp_err),      32'(e[1:0]));
                end
            end
            prev_rv = ifr.rsp_valid;
        end
    end

    // Grant observer for the fixed-priority instance
    always @(negedge clk) begin
        if (!rst) begin
            if (ifp.req0_valid && ifp.req1_ready) fp_r1_bad++;
            if (ifp.req0_valid && ifp.req0_ready) fp_grants.push_back(1'b0);
            if (ifp.req1_valid && ifp.req1_ready) fp_grants.push_back(1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_r && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check_eq("idle_timeout", 32'(n), 32'd0);
    endtask

    // Issue one request on the RR instance; returns #1 after the accepting edge.
    task automatic do_op(input bit id, input bit mode, input logic [7:0] d, input bit clr_in_exec);
        int n = 0;
        @(posedge clk); #1;
        if (id) begin ifr.req1_valid = 1'b1; ifr.req1_mode = mode; ifr.req1_data = d; end
        else    begin ifr.req0_valid = 1'b1; ifr.req0_mode = mode; ifr.req0_data = d; end
        @(negedge clk);
        while (!(id ? ifr.req1_ready : ifr.req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("grant_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        ifr.req0_valid = 1'b0;
        ifr.req1_valid = 1'b0;
        if (clr_in_exec) begin
            clr_r = 1'b1;
            @(posedge clk); #1;
            clr_r = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cw, cw2;
        logic [12:0] exp_bp;
        int          n;
        int          ec;

        ifr.req0_valid = 0; ifr.req0_mode = 0; ifr.req0_data = 0;
        ifr.req1_valid = 0; ifr.req1_mode = 0; ifr.req1_data = 0;
        ifr.rsp_ready  = 1'b1;
        ifp.req0_valid = 0; ifp.req0_mode = 0; ifp.req0_data = 0;
        ifp.req1_valid = 0; ifp.req1_mode = 0; ifp.req1_data = 0;
        ifp.rsp_ready  = 1'b1;
        clr_r = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_valid", 32'(ifr.rsp_valid), 32'd0);
        check_eq("rst_busy",      32'(busy_r), 32'd0);
        check_eq("rst_rsp_word",  32'({ifr.rsp_id, ifr.rsp_mode, ifr.rsp_data, ifr.rsp_syndrome, ifr.rsp_err}), 32'd0);
        check_eq("rst_cdc",       32'({cdc_md_r, cdc_op_r}), 32'd0);
        check_eq("rst_counters",  32'({corr_r, unc_r}), 32'd0);
        check_eq("rst_fp_busy",   32'(busy_p), 32'd0);

        // Contention on both instances: continuous valids, rsp_ready high
        grant_log.delete(); grant_cyc.delete(); fp_grants.delete();
        cw = ham_enc(4'h9);
        @(posedge clk); #1;
        ifr.req0_valid = 1; ifr.req0_mode = 1; ifr.req0_data = cw;
        ifr.req1_valid = 1; ifr.req1_mode = 0; ifr.req1_data = 8'hC3;
        ifp.req0_valid = 1; ifp.req0_mode = 1; ifp.req0_data = cw;
        ifp.req1_valid = 1; ifp.req1_mode = 0; ifp.req1_data = 8'hC3;
        n = 0;
        while (grant_log.size() < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check_eq("rr_grant_timeout", 32'(n), 32'd0);
        ifr.req0_valid = 0; ifr.req1_valid = 0;
        ifp.req0_valid = 0; ifp.req1_valid = 0;
        wait_idle();
        repeat (3) @(negedge clk);
        check_eq("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_eq($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
        for (int i = 1; i < 4 && i < grant_cyc.size(); i++)
            check_eq($sformatf("rr_interval%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
        check_eq("fp_grant_count", 32'(fp_grants.size()), 32'd4);
        for (int i = 0; i < fp_grants.size(); i++)
            check_eq($sformatf("fp_grant%0d", i), 32'(fp_grants[i]), 32'd0);
        check_eq("fp_req1_ready_while_req0", 32'(fp_r1_bad), 32'd0);

        // Single encode on requester 0, [7:4] of the data must be dropped
        @(posedge clk); #1;
        ifr.req0_valid = 1; ifr.req0_mode = 0; ifr.req0_data = 8'hF5;
        @(negedge clk);
        check_eq("enc_ready0", 32'(ifr.req0_ready), 32'd1);
        @(posedge clk); #1;
        ifr.req0_valid = 0;
        @(negedge clk);
        check_eq("enc_cdc_operand", 32'(cdc_op_r), 32'h05);
        check_eq("enc_cdc_mode",    32'(cdc_md_r), 32'd0);
        check_eq("enc_exec_busy",   32'(busy_r), 32'd1);
        check_eq("enc_exec_valid",  32'(ifr.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("enc_rsp_valid", 32'(ifr.rsp_valid), 32'd1);
        check_eq("enc_rsp_id",    32'(ifr.rsp_id), 32'd0);
        check_eq("enc_rsp_data",  32'(ifr.rsp_data), 32'(ham_enc(4'h5)));
        check_eq("enc_rsp_se",    32'({ifr.rsp_syndrome, ifr.rsp_err}), 32'd0);
        wait_idle();

        // Backpressure on a corrected decode; req0 waits meanwhile
        ifr.rsp_ready = 1'b0;
        cw = ham_enc(4'hA) ^ 8'h10;
        exp_bp = ham_dec(cw);
        @(posedge clk); #1;
        ifr.req1_valid = 1; ifr.req1_mode = 1; ifr.req1_data = cw;
        @(negedge clk);
        check_eq("bp_ready1", 32'(ifr.req1_ready), 32'd1);
        @(posedge clk); #1;
        ifr.req1_valid = 0;
        ifr.req0_valid = 1; ifr.req0_mode = 0; ifr.req0_data = 8'h03;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(ifr.rsp_valid), 32'd1);
            check_eq("bp_busy",  32'(busy_r), 32'd1);
            check_eq("bp_data",  32'(ifr.rsp_data), 32'h0A);
            check_eq("bp_se",    32'({ifr.rsp_syndrome, ifr.rsp_err}), 32'(exp_bp[4:0]));
            check_eq("bp_no_grant", 32'(ifr.req0_ready | ifr.req1_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifr.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_release_busy",  32'(busy_r), 32'd0);
        check_eq("bp_release_valid", 32'(ifr.rsp_valid), 32'd0);
        check_eq("bp_release_grant", 32'(ifr.req0_ready), 32'd1);
        @(posedge clk); #1;
        ifr.req0_valid = 0;
        wait_idle();

        // Saturating counters at CNT_W=2 and clear priority
        @(posedge clk); #1 clr_r = 1'b1;
        @(posedge clk); #1 clr_r = 1'b0;
        @(negedge clk);
        check_eq("clr_counters", 32'({corr_r, unc_r}), 32'd0);
        cw  = ham_enc(4'h3) ^ 8'h20;
        cw2 = ham_enc(4'h6) ^ 8'h06;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 1'b1, cw, 1'b0);
            wait_idle();
            ec = (i + 1 > 3) ? 3 : i + 1;
            check_eq($sformatf("cnt_corr%0d", i), 32'(corr_r), 32'(ec));
        end
        do_op(1'b1, 1'b1, cw2, 1'b0);
        wait_idle();
        check_eq("cnt_unc_one", 32'(unc_r), 32'd1);
        do_op(1'b1, 1'b1, cw2, 1'b1);
        wait_idle();
        check_eq("cnt_unc_clr_prio", 32'(unc_r), 32'd0);
        check_eq("cnt_corr_clr",     32'(corr_r), 32'd0);

        // Reset while holding a response
        ifr.rsp_ready = 1'b0;
        do_op(1'b1, 1'b1, cw2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("rm_valid_before", 32'(ifr.rsp_valid), 32'd1);
        check_eq("rm_unc_before",   32'(unc_r), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rm_valid",    32'(ifr.rsp_valid), 32'd0);
        check_eq("rm_busy",     32'(busy_r), 32'd0);
        check_eq("rm_counters", 32'({corr_r, unc_r}), 32'd0);
        check_eq("rm_cdc",      32'(cdc_op_r), 32'd0);
        ifr.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifr.req0_valid = 1; ifr.req0_mode = 0; ifr.req0_data = 8'h07;
        ifr.req1_valid = 1; ifr.req1_mode = 0; ifr.req1_data = 8'h0B;
        @(negedge clk);
        check_eq("rm_tie_ready0", 32'(ifr.req0_ready), 32'd1);
        check_eq("rm_tie_ready1", 32'(ifr.req1_ready), 32'd0);
        @(posedge clk); #1;
        ifr.req0_valid = 0; ifr.req1_valid = 0;
        wait_idle();
        repeat (2) @(negedge clk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
